// File: rtl/mem_access_unit.sv
// Load/store sequencer between the CPU datapath and a word-addressed data RAM.
// Optional MAU_ALIGN_CHECK_EN enables misalignment detection and the err flag.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sx;
        logic [1:0]  lo;
        logic [31:0] wdata;
    } req_t;

    state_t      state, state_nxt;
    req_t        cur;
    logic [31:0] base;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        misal;
    logic        is_sub;

`ifdef MAU_ALIGN_CHECK_EN
    assign misal = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
    assign misal = 1'b0;
`endif

    assign is_sub = ~cur.size[1];

    // Lane extraction; the lane index drops the low bits a half/word ignores.
    always_comb begin
        load_val = ram_rdata;
        case (cur.size)
            2'b00: begin
                load_val = {24'h0, ram_rdata[{cur.lo, 3'b000} +: 8]};
                if (cur.sx && load_val[7]) load_val[31:8] = 24'hFF_FFFF;
            end
            2'b01: begin
                load_val = {16'h0, ram_rdata[{cur.lo[1], 4'b0000} +: 16]};
                if (cur.sx && load_val[15]) load_val[31:16] = 16'hFFFF;
            end
            default: load_val = ram_rdata;
        endcase
    end

    always_comb begin
        merged = base;
        case (cur.size)
            2'b00:   merged[{cur.lo, 3'b000} +: 8]     = cur.wdata[7:0];
            2'b01:   merged[{cur.lo[1], 4'b0000} +: 16] = cur.wdata[15:0];
            default: merged = cur.wdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = misal ? DONE : ACCESS;
            ACCESS:  state_nxt = (cur.we && is_sub) ? WRITE : DONE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write strobe is a pure state decode so reset drops it immediately.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        ram_we    = 1'b0;
        ram_wdata = 32'h0;
        if (state == ACCESS && cur.we && !is_sub) begin
            ram_we    = 1'b1;
            ram_wdata = cur.wdata;
        end else if (state == WRITE) begin
            ram_we    = 1'b1;
            ram_wdata = merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= '0;
            base     <= 32'h0;
            rdata    <= 32'h0;
            ram_addr <= 32'h0;
        end else begin
            if (state == IDLE && req) begin
                cur      <= '{we: we, size: size, sx: sign_ext, lo: addr[1:0], wdata: wdata};
                ram_addr <= {addr[31:2], 2'b00};
            end
            if (state == ACCESS) begin
                if (!cur.we)     rdata <= load_val;
                else if (is_sub) base  <= ram_rdata;
            end
        end
    end

`ifdef MAU_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  err <= 1'b0;
        else if (state == IDLE && req) err <= misal;
    end
`else
    assign err = 1'b0;
`endif

endmodule
